// File: rtl/frame_renderer_if.sv
// Write port between the frame renderer and the frame buffer: a single
// valid/ready write channel carrying buffer index, linear address and pixel.
interface frame_renderer_if #(
   parameter int ADDR_W = 15,
   parameter int PIX_W  = 8
);
   logic              wr_en;
   logic              wr_ready;
   logic              wr_buf;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;

   modport master (
      output wr_en,
      output wr_buf,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_en,
      input  wr_buf,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/frame_renderer.sv
// Back-buffer fill engine: one raster scan per start pulse, drawing a solid car
// rectangle over a flat background through a stallable write port.
module frame_renderer #(
   parameter int               FB_W      = 160,
   parameter int               FB_H      = 120,
   parameter int               PIX_W     = 8,
   parameter int               ADDR_W    = 15,
   parameter int               CAR_W     = 16,
   parameter int               CAR_H     = 8,
   parameter logic [PIX_W-1:0] BG_COLOR  = 8'h00,
   parameter logic [PIX_W-1:0] CAR_COLOR = 8'hE0
) (
   input  logic             clk_sys,
   input  logic             srst,
   input  logic             i_start_render,
   input  logic             i_back_sel,
   input  logic [7:0]       i_car_x,
   input  logic [6:0]       i_car_y,
   output logic             o_render_idle,
   output logic             o_frame_done,
   output logic             o_start_dropped,
   frame_renderer_if.master wr
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t            r_state;
   logic              r_render_idle;
   logic              r_frame_done;
   logic              r_start_dropped;
   logic              r_wr_en;
   logic              r_wr_buf;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [PIX_W-1:0]  r_wr_data;
   logic [7:0]        r_x;
   logic [6:0]        r_y;
   logic [7:0]        r_car_x;
   logic [6:0]        r_car_y;

   logic              w_accept;
   logic              w_last_pix;
   logic [7:0]        w_next_x;
   logic [6:0]        w_next_y;

   // Bounds are widened by one bit so a car near the right/bottom edge clips
   // instead of wrapping back to column/row 0.
   function automatic logic [PIX_W-1:0] pix_color(input logic [7:0] px,
                                                  input logic [6:0] py,
                                                  input logic [7:0] cx,
                                                  input logic [6:0] cy);
      logic [8:0] x_end;
      logic [7:0] y_end;
      logic       in_x;
      logic       in_y;
      x_end = {1'b0, cx} + 9'(CAR_W);
      y_end = {1'b0, cy} + 8'(CAR_H);
      in_x  = (px >= cx) && ({1'b0, px} < x_end);
      in_y  = (py >= cy) && ({1'b0, py} < y_end);
      return (in_x && in_y) ? CAR_COLOR : BG_COLOR;
   endfunction

   // NOTE: every always_comb output gets a value on every path, so no latch.
   always_comb begin
      w_accept   = r_wr_en && wr.wr_ready;
      w_last_pix = (r_x == 8'(FB_W - 1)) && (r_y == 7'(FB_H - 1));
      w_next_x   = r_x + 8'd1;
      w_next_y   = r_y;
      if (r_x == 8'(FB_W - 1)) begin
         w_next_x = '0;
         w_next_y = r_y + 7'd1;
      end
   end

   // NOTE: state is updated only with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys or posedge srst) begin
      if (srst) begin
         r_state         <= S_IDLE;
         r_render_idle   <= 1'b1;
         r_frame_done    <= 1'b0;
         r_start_dropped <= 1'b0;
         r_wr_en         <= 1'b0;
         r_wr_buf        <= 1'b0;
         r_wr_addr       <= '0;
         r_wr_data       <= '0;
         r_x             <= '0;
         r_y             <= '0;
         r_car_x         <= '0;
         r_car_y         <= '0;
      end else begin
         r_frame_done    <= 1'b0;
         r_start_dropped <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start_render) begin
                  r_state       <= S_FILL;
                  r_render_idle <= 1'b0;
                  r_wr_en       <= 1'b1;
                  r_wr_buf      <= i_back_sel;
                  r_car_x       <= i_car_x;
                  r_car_y       <= i_car_y;
                  r_x           <= '0;
                  r_y           <= '0;
                  r_wr_addr     <= '0;
                  // First pixel colour must use the position being latched now.
                  r_wr_data     <= pix_color(8'd0, 7'd0, i_car_x, i_car_y);
               end
            end
            S_FILL: begin
               if (i_start_render) r_start_dropped <= 1'b1;
               if (w_accept) begin
                  if (w_last_pix) begin
                     r_state       <= S_IDLE;
                     r_render_idle <= 1'b1;
                     r_wr_en       <= 1'b0;
                     r_frame_done  <= 1'b1;
                  end else begin
                     r_x       <= w_next_x;
                     r_y       <= w_next_y;
                     r_wr_addr <= r_wr_addr + ADDR_W'(1);
                     r_wr_data <= pix_color(w_next_x, w_next_y, r_car_x, r_car_y);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_render_idle   = r_render_idle;
   assign o_frame_done    = r_frame_done;
   assign o_start_dropped = r_start_dropped;
   assign wr.wr_en        = r_wr_en;
   assign wr.wr_buf       = r_wr_buf;
   assign wr.wr_addr      = r_wr_addr;
   assign wr.wr_data      = r_wr_data;

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench for frame_renderer: a per-pixel rectangle model fills the
// expected-write queue at each start; a negedge monitor pops and compares.
module tb_frame_renderer;
   localparam int         FB_W      = 160;
   localparam int         FB_H      = 120;
   localparam int         PIX_W     = 8;
   localparam int         ADDR_W    = 15;
   localparam int         CAR_W     = 16;
   localparam int         CAR_H     = 8;
   localparam logic [7:0] BG_COLOR  = 8'h00;
   localparam logic [7:0] CAR_COLOR = 8'hE0;
   localparam int         NPIX      = FB_W * FB_H;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [PIX_W-1:0]  data;
      logic              bsel;
      bit                last;
   } wr_t;

   logic       clk_sys        = 1'b0;
   logic       srst           = 1'b1;
   logic       i_start_render = 1'b0;
   logic       i_back_sel     = 1'b0;
   logic [7:0] i_car_x        = '0;
   logic [6:0] i_car_y        = '0;
   logic       o_render_idle;
   logic       o_frame_done;
   logic       o_start_dropped;

   frame_renderer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) wr_if ();

   frame_renderer #(
      .FB_W(FB_W), .FB_H(FB_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
      .CAR_W(CAR_W), .CAR_H(CAR_H), .BG_COLOR(BG_COLOR), .CAR_COLOR(CAR_COLOR)
   ) dut (
      .clk_sys         (clk_sys),
      .srst            (srst),
      .i_start_render  (i_start_render),
      .i_back_sel      (i_back_sel),
      .i_car_x         (i_car_x),
      .i_car_y         (i_car_y),
      .o_render_idle   (o_render_idle),
      .o_frame_done    (o_frame_done),
      .o_start_dropped (o_start_dropped),
      .wr              (wr_if)
   );

   wr_t sb[$];
   int  exp_car[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  n_acc    = 0;
   bit  rnd_ready = 1'b0;

   initial forever #5 clk_sys = ~clk_sys;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected frame straight from the drawing rule: pixel a sits at
   // (a mod W, a div W) and is car-coloured iff inside the rectangle.
   task automatic push_frame(input int cx, input int cy, input bit bs);
      for (int a = 0; a < NPIX; a++) begin
         int  x;
         int  y;
         bit  on_car;
         wr_t e;
         x      = a % FB_W;
         y      = a / FB_W;
         on_car = (x >= cx) && (x < cx + CAR_W) && (y >= cy) && (y < cy + CAR_H);
         e.addr = ADDR_W'(a);
         e.data = on_car ? CAR_COLOR : BG_COLOR;
         e.bsel = bs;
         e.last = (a == NPIX - 1);
         sb.push_back(e);
      end
   endtask

   // Called just after a rising edge; start is sampled on the next edge.
   task automatic do_start(input int cx, input int cy, input bit bs, input int ncar);
      push_frame(cx, cy, bs);
      exp_car.push_back(ncar);
      i_car_x        = 8'(cx);
      i_car_y        = 7'(cy);
      i_back_sel     = bs;
      i_start_render = 1'b1;
      @(posedge clk_sys);
      #1;
      i_start_render = 1'b0;
      check("start_idle_low", o_render_idle, 0);
      check("start_wr_en", wr_if.wr_en, 1);
      check("start_addr0", wr_if.wr_addr, 0);
      // Mid-frame input changes must not affect the frame in progress.
      i_car_x    = 8'($urandom);
      i_car_y    = 7'($urandom);
      i_back_sel = 1'($urandom);
   endtask

   task automatic wait_acc(input int n);
      int cyc = 0;
      while (n_acc < n && cyc < 4 * n + 100) begin
         @(posedge clk_sys);
         #1;
         cyc++;
      end
      check("accept_count_reached", (n_acc >= n), 1);
   endtask

   task automatic wait_idle();
      int cyc = 0;
      do begin
         @(posedge clk_sys);
         #1;
         cyc++;
      end while (!o_render_idle && cyc < 3 * NPIX);
      check("idle_reached", o_render_idle, 1);
   endtask

   initial forever begin
      @(posedge clk_sys);
      #1;
      wr_if.wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: compares every accepted write, stall stability and frame end.
   initial begin
      wr_t e;
      wr_t held;
      bit  pend_done = 1'b0;
      bit  stalled   = 1'b0;
      int  car_cnt   = 0;
      forever begin
         @(negedge clk_sys);
         if (srst) begin
            pend_done = 1'b0;
            stalled   = 1'b0;
            car_cnt   = 0;
            n_acc     = 0;
         end else begin
            if (pend_done) begin
               check("frame_done_pulse", o_frame_done, 1);
               check("idle_after_frame", o_render_idle, 1);
               check("wr_en_after_frame", wr_if.wr_en, 0);
               if (exp_car.size() != 0) begin
                  check("car_pixel_count", car_cnt, exp_car.pop_front());
               end else begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL car_pixel_count: frame ended with no expectation queued");
               end
               pend_done = 1'b0;
               car_cnt   = 0;
               n_acc     = 0;
            end else begin
               check("frame_done_quiet", o_frame_done, 0);
            end
            if (stalled) begin
               check("stall_wr_en", wr_if.wr_en, 1);
               check("stall_addr", wr_if.wr_addr, held.addr);
               check("stall_data", wr_if.wr_data, held.data);
               check("stall_buf", wr_if.wr_buf, held.bsel);
            end
            stalled = 1'b0;
            if (wr_if.wr_en && wr_if.wr_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_write: addr %0d with empty scoreboard", wr_if.wr_addr);
               end else begin
                  e = sb.pop_front();
                  check("wr_addr", wr_if.wr_addr, e.addr);
                  check("wr_data", wr_if.wr_data, e.data);
                  check("wr_buf", wr_if.wr_buf, e.bsel);
                  if (wr_if.wr_data == CAR_COLOR) car_cnt++;
                  n_acc++;
                  if (e.last) pend_done = 1'b1;
               end
            end else if (wr_if.wr_en) begin
               stalled   = 1'b1;
               held.addr = wr_if.wr_addr;
               held.data = wr_if.wr_data;
               held.bsel = wr_if.wr_buf;
            end
         end
      end
   end

   initial begin
      int cx;
      int cy;
      bit bs;
      wr_if.wr_ready = 1'b1;
      #23;
      check("rst_idle", o_render_idle, 1);
      check("rst_wr_en", wr_if.wr_en, 0);
      check("rst_wr_buf", wr_if.wr_buf, 0);
      check("rst_wr_addr", wr_if.wr_addr, 0);
      check("rst_wr_data", wr_if.wr_data, 0);
      check("rst_frame_done", o_frame_done, 0);
      check("rst_start_dropped", o_start_dropped, 0);
      @(negedge clk_sys);
      srst = 1'b0;
      @(posedge clk_sys);
      #1;

      // Frame 1: car fully inside, ready tied high, extra start at write 1000.
      do_start(10, 20, 1'b1, 128);
      wait_acc(1000);
      i_car_x        = 8'd0;
      i_car_y        = 7'd0;
      i_back_sel     = 1'b0;
      i_start_render = 1'b1;
      @(posedge clk_sys);
      #1;
      i_start_render = 1'b0;
      @(negedge clk_sys);
      check("start_dropped_pulse", o_start_dropped, 1);
      @(negedge clk_sys);
      check("start_dropped_single", o_start_dropped, 0);
      wait_idle();

      // Frame 2: started on the very cycle idle rises; car clipped to 10x5.
      do_start(150, 115, 1'b0, 50);
      wait_idle();

      // Frame 3: random position and 50% ready, aborted by reset at write 5000.
      rnd_ready = 1'b1;
      cx = $urandom_range(0, 255);
      cy = $urandom_range(0, 127);
      bs = 1'($urandom);
      do_start(cx, cy, bs, -1);
      wait_acc(5000);
      #2;
      srst = 1'b1;
      #1;
      check("srst_wr_en", wr_if.wr_en, 0);
      check("srst_idle", o_render_idle, 1);
      check("srst_addr", wr_if.wr_addr, 0);
      check("srst_data", wr_if.wr_data, 0);
      check("srst_buf", wr_if.wr_buf, 0);
      check("srst_frame_done", o_frame_done, 0);
      sb.delete();
      exp_car.delete();
      rnd_ready = 1'b0;

      // Frame 4: start held across reset release, car off-screen to the right.
      cy = $urandom_range(0, 127);
      push_frame(200, cy, 1'b1);
      exp_car.push_back(0);
      i_car_x        = 8'd200;
      i_car_y        = 7'(cy);
      i_back_sel     = 1'b1;
      i_start_render = 1'b1;
      @(negedge clk_sys);
      srst = 1'b0;
      @(posedge clk_sys);
      #1;
      i_start_render = 1'b0;
      check("post_rst_start_wr_en", wr_if.wr_en, 1);
      check("post_rst_start_addr", wr_if.wr_addr, 0);
      check("post_rst_start_idle", o_render_idle, 0);
      wait_idle();

      repeat (3) @(posedge clk_sys);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      check("car_expectations_drained", exp_car.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
